wb_burst_slave_mem: RTL and testbench
=====================================

// Module: wb_burst_slave_mem
// PURPOSE
//  Wishbone B3 slave (responder) backed by a word-addressed on-chip RAM.
//  Supports classic and registered-feedback burst cycles (CTI/BTE) and
//  signals ERR on out-of-range addresses. Sits on the slave side of the
//  bus as the memory end for AXI-to-Wishbone bridged masters.
// PARAMETERS
//  WB_ADR_WIDTH  32    byte address width
//  WB_DAT_WIDTH  32    data width
//  WB_SEL_WIDTH  4     byte selects (WB_DAT_WIDTH/8)
//  WB_TGA_WIDTH  8     address tag width (carries AXI ID)
//  WB_TGD_WIDTH  8     data tag width
//  WB_TGC_WIDTH  4     cycle tag width
//  WB_CTI_WIDTH  3     cycle type identifier width
//  WB_BTE_WIDTH  2     burst type extension width
//  MEM_DEPTH     1024  RAM words; need not be a power of two
// PORTS
//  CLK_I  in   1             clock, all logic on rising edge
//  RST_I  in   1             synchronous reset, active high
//  ADR_I  in   WB_ADR_WIDTH  byte address; word index = ADR_I>>log2(WB_SEL_WIDTH)
//  TGA_I  in   WB_TGA_WIDTH  address tag, latched per access
//  DAT_I  in   WB_DAT_WIDTH  write data
//  TGD_I  in   WB_TGD_WIDTH  ignored
//  DAT_O  out  WB_DAT_WIDTH  read data, valid while ACK_O high
//  TGD_O  out  WB_TGD_WIDTH  echo of latched TGA_I (zero-extended or truncated)
//  WE_I   in   1             1 = write
//  SEL_I  in   WB_SEL_WIDTH  byte write enables
//  STB_I  in   1             strobe
//  CYC_I  in   1             cycle valid
//  ACK_O  out  1             normal termination
//  ERR_O  out  1             error termination
//  RTY_O  out  1             tied 0
//  LOCK_I in   1             ignored
//  CTI_I  in   WB_CTI_WIDTH  000 classic, 001 const, 010 incr, 111 end-of-burst
//  BTE_I  in   WB_BTE_WIDTH  00 linear, 01 wrap4, 10 wrap8, 11 wrap16
//  TGC_I  in   WB_TGC_WIDTH  ignored
// BEHAVIOUR
//  - Reset: ACK_O, ERR_O, RTY_O, DAT_O, TGD_O = 0; state IDLE; addr counter = 0.
//  - req = CYC_I & STB_I. In IDLE, accept req only when ACK_O=0 and ERR_O=0.
//    This prevents a second acknowledge of a classic transfer already acked.
//  - Accept: latch word index, TGA_I and BTE_I. If index >= MEM_DEPTH, ERR_O=1
//    for one cycle, no RAM write, return to IDLE. Otherwise ACK_O=1 on the
//    next cycle (one wait state on the first beat).
//  - CTI_I at accept: 000 or reserved (011..110, 111) -> state CLASSIC, one ACK,
//    then IDLE. 010 -> BURST_INC. 001 -> BURST_CONST.
//  - BURST_*: ACK_O stays high every cycle while req holds, so later beats
//    have zero wait states. Beat completes on an edge with ACK_O & req.
//    Address advances after each beat: INC = +1 under BTE wrap (low 2/3/4
//    bits wrap, upper bits held); CONST = hold.
//  - Master wait (STB_I=0, CYC_I=1) in a burst: ACK_O=0 next cycle, address
//    held, resume on STB_I=1.
//  - Completing beat with CTI_I=111: ACK_O=0 next cycle, go to IDLE.
//  - Beat whose next address is >= MEM_DEPTH: that beat takes ERR_O instead of
//    ACK_O, the burst terminates, go to IDLE.
//  - CYC_I=0 in any state: go to IDLE, ACK_O/ERR_O = 0 next cycle; an
//    in-flight write is not committed.
//  - Write: on a completing beat with WE_I=1, RAM bytes with SEL_I[b]=1 take DAT_I.
//  - Read: DAT_O is registered from the RAM at the current address, so it is
//    valid in the same cycle as ACK_O. RAM read is combinational-in/registered-out.
//  - Read-after-write to the same word in back-to-back beats returns the new data.
//  - RST_I mid-burst: reset values next cycle; RAM contents preserved.
// CONFIGURATION
//  WB_SLV_BTE_WRAP_EN defined: BTE wrap modes honoured as above.
//  Not defined: BTE_I ignored; every incrementing burst is linear.
// STRUCTURE
//  - Shared package wb_pkg:
//    - cti_e {CTI_CLASSIC=3'b000, CTI_CONST=3'b001, CTI_INCR=3'b010, CTI_EOB=3'b111}
//    - bte_e {BTE_LINEAR, BTE_WRAP4, BTE_WRAP8, BTE_WRAP16}
//    - state enum {IDLE, CLASSIC, BURST_INC, BURST_CONST}
//  - Sub-module wb_burst_addr_gen: combinational next-word-index from current
//    index, CTI and BTE, including the wrap mask.
// TESTING
//  1 Classic write 0xDEADBEEF @0x10, SEL=1111, then classic read @0x10
//    -> ACK one cycle per transfer, 1 wait state, DAT_O=0xDEADBEEF.
//  2 SEL=0010 write 0x0000AB00 over 0xDEADBEEF -> read gives 0xDEADABEF.
//  3 Incr burst, wrap4, start 0x18, 4 reads with last CTI=111
//    -> word order 6,7,4,5; ACK continuous after first beat; ACK drops after EOB.
//  4 Classic read @0x1000 (index 1024 >= MEM_DEPTH) -> ERR_O one cycle,
//    ACK_O=0, RAM unchanged.
//  5 Linear burst write 8 beats, master drops STB for 2 cycles after beat 3
//    -> ACK_O low during the gap, 8 distinct words written, none skipped.
//  6 RST_I in mid-burst, or CYC_I=0 in mid-burst -> ACK_O=0 next cycle,
//    IDLE, new classic access works.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone B3 types: cycle type identifiers, burst type extensions
// and the burst slave state encoding.
package wb_pkg;

   typedef enum logic [2:0] {
      CTI_CLASSIC = 3'b000,
      CTI_CONST   = 3'b001,
      CTI_INCR    = 3'b010,
      CTI_EOB     = 3'b111
   } cti_e;

   typedef enum logic [1:0] {
      BTE_LINEAR = 2'b00,
      BTE_WRAP4  = 2'b01,
      BTE_WRAP8  = 2'b10,
      BTE_WRAP16 = 2'b11
   } bte_e;

   typedef enum logic [1:0] {
      IDLE        = 2'b00,
      CLASSIC     = 2'b01,
      BURST_INC   = 2'b10,
      BURST_CONST = 2'b11
   } wb_state_e;

endpackage

// File: rtl/wb_burst_addr_gen.sv
// Next word index for a Wishbone burst beat. Wrap modes are honoured only
// when WB_SLV_BTE_WRAP_EN is defined; otherwise every increment is linear.
module wb_burst_addr_gen
   import wb_pkg::*;
#(
   parameter int WORD_W = 30
) (
   input  logic [WORD_W-1:0] cur_idx,
   input  cti_e              cti,
   input  bte_e              bte,
   output logic [WORD_W-1:0] nxt_idx
);

   logic [WORD_W-1:0] inc_idx;
   logic [WORD_W-1:0] wrap_mask;

   always_comb begin
      inc_idx = cur_idx + WORD_W'(1);
`ifdef WB_SLV_BTE_WRAP_EN
      case (bte)
         BTE_WRAP4:  wrap_mask = WORD_W'(3);
         BTE_WRAP8:  wrap_mask = WORD_W'(7);
         BTE_WRAP16: wrap_mask = WORD_W'(15);
         default:    wrap_mask = '1;
      endcase
`else
      wrap_mask = '1;
`endif
      // Bits outside the mask keep their value, so a wrap stays inside its aligned block.
      if (cti == CTI_INCR) nxt_idx = (cur_idx & ~wrap_mask) | (inc_idx & wrap_mask);
      else                 nxt_idx = cur_idx;
   end

`ifndef WB_SLV_BTE_WRAP_EN
   bte_e unused_bte;
   assign unused_bte = bte;
`endif

endmodule

// File: rtl/wb_burst_slave_mem.sv
// Wishbone B3 burst slave in front of a word-addressed RAM with ERR on
// out-of-range words. Define WB_SLV_BTE_WRAP_EN to honour BTE wrap bursts.
module wb_burst_slave_mem
   import wb_pkg::*;
#(
   parameter int WB_ADR_WIDTH = 32,
   parameter int WB_DAT_WIDTH = 32,
   parameter int WB_SEL_WIDTH = 4,
   parameter int WB_TGA_WIDTH = 8,
   parameter int WB_TGD_WIDTH = 8,
   parameter int WB_TGC_WIDTH = 4,
   parameter int WB_CTI_WIDTH = 3,
   parameter int WB_BTE_WIDTH = 2,
   parameter int MEM_DEPTH    = 1024
) (
   input  logic                    CLK_I,
   input  logic                    RST_I,
   input  logic [WB_ADR_WIDTH-1:0] ADR_I,
   input  logic [WB_TGA_WIDTH-1:0] TGA_I,
   input  logic [WB_DAT_WIDTH-1:0] DAT_I,
   input  logic [WB_TGD_WIDTH-1:0] TGD_I,
   output logic [WB_DAT_WIDTH-1:0] DAT_O,
   output logic [WB_TGD_WIDTH-1:0] TGD_O,
   input  logic                    WE_I,
   input  logic [WB_SEL_WIDTH-1:0] SEL_I,
   input  logic                    STB_I,
   input  logic                    CYC_I,
   output logic                    ACK_O,
   output logic                    ERR_O,
   output logic                    RTY_O,
   input  logic                    LOCK_I,
   input  logic [WB_CTI_WIDTH-1:0] CTI_I,
   input  logic [WB_BTE_WIDTH-1:0] BTE_I,
   input  logic [WB_TGC_WIDTH-1:0] TGC_I
);

   localparam int SEL_SHIFT = $clog2(WB_SEL_WIDTH);
   localparam int WORD_W    = WB_ADR_WIDTH - SEL_SHIFT;
   localparam int MEM_AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [WORD_W-1:0] DEPTH_W = WORD_W'(MEM_DEPTH);

   wb_state_e               state_q, state_d;
   logic [WORD_W-1:0]       addr_q, addr_d, nxt_idx, req_idx, rd_idx;
   bte_e                    bte_q;
   cti_e                    burst_cti;
   logic                    req, accept, ack_d, err_d, dat_ld, mem_we;
   logic [WB_DAT_WIDTH-1:0] mem [MEM_DEPTH];
   logic [WB_DAT_WIDTH-1:0] cur_word, wr_word, rd_word, dat_d;
   logic [WB_TGD_WIDTH-1:0] tga_fit;

   function automatic logic in_range(input logic [WORD_W-1:0] idx);
      return idx < DEPTH_W;
   endfunction

   function automatic logic [WB_DAT_WIDTH-1:0] merge_bytes(
      input logic [WB_DAT_WIDTH-1:0] old_w,
      input logic [WB_DAT_WIDTH-1:0] new_w,
      input logic [WB_SEL_WIDTH-1:0] sel
   );
      logic [WB_DAT_WIDTH-1:0] res;
      res = old_w;
      for (int b = 0; b < WB_SEL_WIDTH; b++)
         if (sel[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
      return res;
   endfunction

   generate
      if (WB_TGD_WIDTH <= WB_TGA_WIDTH) begin : g_tag_trunc
         assign tga_fit = TGA_I[WB_TGD_WIDTH-1:0];
      end else begin : g_tag_ext
         assign tga_fit = {{(WB_TGD_WIDTH-WB_TGA_WIDTH){1'b0}}, TGA_I};
      end
   endgenerate

   assign req       = CYC_I & STB_I;
   assign req_idx   = ADR_I[WB_ADR_WIDTH-1:SEL_SHIFT];
   assign burst_cti = (state_q == BURST_INC) ? CTI_INCR : CTI_CONST;
   assign RTY_O     = 1'b0;

   wb_burst_addr_gen #(.WORD_W(WORD_W)) u_addr_gen (
      .cur_idx (addr_q),
      .cti     (burst_cti),
      .bte     (bte_q),
      .nxt_idx (nxt_idx)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rd_idx  = addr_q;
      accept  = 1'b0;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      dat_ld  = 1'b0;
      mem_we  = 1'b0;
      if (!CYC_I) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               // A classic transfer still showing ACK/ERR must not be taken twice.
               if (req && !ACK_O && !ERR_O) begin
                  accept = 1'b1;
                  addr_d = req_idx;
                  if (!in_range(req_idx))                           err_d   = 1'b1;
                  else if (CTI_I == WB_CTI_WIDTH'(CTI_INCR))        state_d = BURST_INC;
                  else if (CTI_I == WB_CTI_WIDTH'(CTI_CONST))       state_d = BURST_CONST;
                  else                                              state_d = CLASSIC;
               end
            end
            CLASSIC: begin
               if (req) begin
                  if (ACK_O) begin
                     mem_we  = WE_I;
                     state_d = IDLE;
                  end else begin
                     ack_d  = 1'b1;
                     dat_ld = 1'b1;
                  end
               end
            end
            default: begin
               if (req) begin
                  if (ACK_O) begin
                     mem_we = WE_I;
                     addr_d = nxt_idx;
                     if (CTI_I == WB_CTI_WIDTH'(CTI_EOB)) begin
                        state_d = IDLE;
                     end else if (!in_range(nxt_idx)) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                     end else begin
                        ack_d  = 1'b1;
                        dat_ld = 1'b1;
                        rd_idx = nxt_idx;
                     end
                  end else begin
                     ack_d  = 1'b1;
                     dat_ld = 1'b1;
                  end
               end
            end
         endcase
      end
   end

   assign cur_word = mem[addr_q[MEM_AW-1:0]];
   assign wr_word  = merge_bytes(cur_word, DAT_I, SEL_I);
   assign rd_word  = in_range(rd_idx) ? mem[rd_idx[MEM_AW-1:0]] : '0;
   // A constant-address beat reads back the word being written on the same edge.
   assign dat_d    = (mem_we && (rd_idx == addr_q)) ? wr_word : rd_word;

   always_ff @(posedge CLK_I) begin
      if (RST_I) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         ACK_O  <= 1'b0;
         ERR_O  <= 1'b0;
         DAT_O  <= '0;
         TGD_O  <= '0;
         addr_q <= '0;
         bte_q  <= BTE_LINEAR;
      end else begin
         ACK_O  <= ack_d;
         ERR_O  <= err_d;
         addr_q <= addr_d;
         if (dat_ld) DAT_O <= dat_d;
         if (accept) begin
            TGD_O <= tga_fit;
            bte_q <= bte_e'(BTE_I);
         end
      end
   end

   always_ff @(posedge CLK_I) begin
      if (mem_we && !RST_I) mem[addr_q[MEM_AW-1:0]] <= wr_word;
   end

   logic unused_inputs;
   assign unused_inputs = ^{TGD_I, LOCK_I, TGC_I, ADR_I[SEL_SHIFT-1:0]};

endmodule

// File: tb/tb_wb_burst_slave_mem.sv
// Directed bench for wb_burst_slave_mem: classic, byte-select, wrap and
// linear bursts, master wait, error termination, reset and abort.
module tb_wb_burst_slave_mem;

   logic        clk = 1'b0;
   logic        RST_I;
   logic [31:0] ADR_I;
   logic [7:0]  TGA_I;
   logic [31:0] DAT_I;
   logic [7:0]  TGD_I;
   logic [31:0] DAT_O;
   logic [7:0]  TGD_O;
   logic        WE_I;
   logic [3:0]  SEL_I;
   logic        STB_I;
   logic        CYC_I;
   logic        ACK_O;
   logic        ERR_O;
   logic        RTY_O;
   logic        LOCK_I;
   logic [2:0]  CTI_I;
   logic [1:0]  BTE_I;
   logic [3:0]  TGC_I;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   wb_burst_slave_mem dut (
      .CLK_I(clk), .RST_I(RST_I), .ADR_I(ADR_I), .TGA_I(TGA_I), .DAT_I(DAT_I),
      .TGD_I(TGD_I), .DAT_O(DAT_O), .TGD_O(TGD_O), .WE_I(WE_I), .SEL_I(SEL_I),
      .STB_I(STB_I), .CYC_I(CYC_I), .ACK_O(ACK_O), .ERR_O(ERR_O), .RTY_O(RTY_O),
      .LOCK_I(LOCK_I), .CTI_I(CTI_I), .BTE_I(BTE_I), .TGC_I(TGC_I)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // One classic transfer: holds the request through the terminating edge,
   // then reports latency, data and what the bus shows right after.
   task automatic do_classic(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, output logic [31:0] rd, output int n_term,
                             output logic got_err, output logic ack_after, output logic err_after);
      CYC_I = 1'b1; STB_I = 1'b1; WE_I = we; ADR_I = adr; DAT_I = dat; SEL_I = sel;
      CTI_I = 3'b000; BTE_I = 2'b00;
      n_term = 99; got_err = 1'b0; rd = '0;
      for (int i = 1; i <= 8; i++) begin
         tick;
         if (ACK_O || ERR_O) begin
            n_term = i; got_err = ERR_O; rd = DAT_O;
            break;
         end
      end
      tick;
      ack_after = ACK_O; err_after = ERR_O;
      CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
      tick;
   endtask

   task automatic test_reset;
      RST_I = 1'b1;
      repeat (3) tick;
      checks++; if (ACK_O !== 1'b0) begin errors++; $display("FAIL rst_ack got=%b exp=0", ACK_O); end
      checks++; if (ERR_O !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", ERR_O); end
      checks++; if (RTY_O !== 1'b0) begin errors++; $display("FAIL rst_rty got=%b exp=0", RTY_O); end
      checks++; if (DAT_O !== 32'h0) begin errors++; $display("FAIL rst_dat got=%h exp=0", DAT_O); end
      checks++; if (TGD_O !== 8'h0) begin errors++; $display("FAIL rst_tgd got=%h exp=0", TGD_O); end
      RST_I = 1'b0;
      tick;
   endtask

   task automatic test_classic;
      logic [31:0] rd; int n; logic e, aa, ea;
      TGA_I = 8'h5A;
      do_classic(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, n, e, aa, ea);
      checks++; if (n !== 2) begin errors++; $display("FAIL t1_wr_latency got=%0d exp=2", n); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL t1_wr_err got=%b exp=0", e); end
      checks++; if (aa !== 1'b0) begin errors++; $display("FAIL t1_wr_single_ack got=%b exp=0", aa); end
      checks++; if (TGD_O !== 8'h5A) begin errors++; $display("FAIL t1_wr_tgd got=%h exp=5a", TGD_O); end
      TGA_I = 8'h3C;
      do_classic(1'b0, 32'h10, 32'h0, 4'hF, rd, n, e, aa, ea);
      checks++; if (n !== 2) begin errors++; $display("FAIL t1_rd_latency got=%0d exp=2", n); end
      checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL t1_rd_data got=%h exp=deadbeef", rd); end
      checks++; if (aa !== 1'b0) begin errors++; $display("FAIL t1_rd_single_ack got=%b exp=0", aa); end
      checks++; if (TGD_O !== 8'h3C) begin errors++; $display("FAIL t1_rd_tgd got=%h exp=3c", TGD_O); end
   endtask

   task automatic test_byte_sel;
      logic [31:0] rd; int n; logic e, aa, ea;
      do_classic(1'b1, 32'h10, 32'h0000AB00, 4'b0010, rd, n, e, aa, ea);
      do_classic(1'b0, 32'h10, 32'h0, 4'hF, rd, n, e, aa, ea);
      checks++; if (rd !== 32'hDEADABEF) begin errors++; $display("FAIL t2_sel_merge got=%h exp=deadabef", rd); end
   endtask

   task automatic test_wrap_burst;
      logic [31:0] rd; int n; logic e, aa, ea;
      int exp_idx [4];
`ifdef WB_SLV_BTE_WRAP_EN
      exp_idx[0] = 6; exp_idx[1] = 7; exp_idx[2] = 4; exp_idx[3] = 5;
`else
      exp_idx[0] = 6; exp_idx[1] = 7; exp_idx[2] = 8; exp_idx[3] = 9;
`endif
      for (int w = 4; w <= 9; w++)
         do_classic(1'b1, 32'(w * 4), 32'hC0DE0000 + 32'(w), 4'hF, rd, n, e, aa, ea);
      CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0; ADR_I = 32'h18; SEL_I = 4'hF;
      CTI_I = 3'b010; BTE_I = 2'b01;
      tick;
      checks++; if (ACK_O !== 1'b0) begin errors++; $display("FAIL t3_first_wait got=%b exp=0", ACK_O); end
      tick;
      for (int b = 0; b < 4; b++) begin
         if (b > 0) tick;
         if (b == 3) CTI_I = 3'b111;
         checks++;
         if (ACK_O !== 1'b1 || DAT_O !== 32'hC0DE0000 + 32'(exp_idx[b])) begin
            errors++;
            $display("FAIL t3_beat%0d got ack=%b dat=%h exp ack=1 dat=%h", b, ACK_O, DAT_O,
                     32'hC0DE0000 + 32'(exp_idx[b]));
         end
      end
      tick;
      checks++; if (ACK_O !== 1'b0) begin errors++; $display("FAIL t3_eob_drop got=%b exp=0", ACK_O); end
      CYC_I = 1'b0; STB_I = 1'b0; CTI_I = 3'b000; BTE_I = 2'b00;
      tick;
   endtask

   task automatic test_out_of_range;
      logic [31:0] rd; int n; logic e, aa, ea;
      do_classic(1'b1, 32'h0, 32'h11111111, 4'hF, rd, n, e, aa, ea);
      do_classic(1'b0, 32'h1000, 32'h0, 4'hF, rd, n, e, aa, ea);
      checks++; if (n !== 1 || e !== 1'b1) begin errors++; $display("FAIL t4_rd_err got n=%0d err=%b exp n=1 err=1", n, e); end
      checks++; if (aa !== 1'b0 || ea !== 1'b0) begin errors++; $display("FAIL t4_err_once got ack=%b err=%b exp 0 0", aa, ea); end
      do_classic(1'b1, 32'h1000, 32'hBAD0BAD0, 4'hF, rd, n, e, aa, ea);
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL t4_wr_err got=%b exp=1", e); end
      do_classic(1'b0, 32'h0, 32'h0, 4'hF, rd, n, e, aa, ea);
      checks++; if (rd !== 32'h11111111) begin errors++; $display("FAIL t4_ram_unchanged got=%h exp=11111111", rd); end
   endtask

   task automatic test_gap_burst;
      logic [31:0] rd; int n; logic e, aa, ea;
      CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; ADR_I = 32'h100; SEL_I = 4'hF;
      CTI_I = 3'b010; BTE_I = 2'b00; DAT_I = 32'hA5000000;
      tick;
      checks++; if (ACK_O !== 1'b0) begin errors++; $display("FAIL t5_first_wait got=%b exp=0", ACK_O); end
      tick;
      checks++; if (ACK_O !== 1'b1) begin errors++; $display("FAIL t5_beat0_ack got=%b exp=1", ACK_O); end
      for (int b = 1; b <= 2; b++) begin
         tick;
         DAT_I = 32'hA5000000 + 32'(b);
         checks++; if (ACK_O !== 1'b1) begin errors++; $display("FAIL t5_beat%0d_ack got=%b exp=1", b, ACK_O); end
      end
      tick;
      STB_I = 1'b0;
      for (int g = 0; g < 2; g++) begin
         tick;
         checks++; if (ACK_O !== 1'b0) begin errors++; $display("FAIL t5_gap%0d_ack got=%b exp=0", g, ACK_O); end
      end
      STB_I = 1'b1; DAT_I = 32'hA5000003;
      tick;
      checks++; if (ACK_O !== 1'b1) begin errors++; $display("FAIL t5_resume_ack got=%b exp=1", ACK_O); end
      for (int b = 4; b <= 7; b++) begin
         tick;
         DAT_I = 32'hA5000000 + 32'(b);
         if (b == 7) CTI_I = 3'b111;
         checks++; if (ACK_O !== 1'b1) begin errors++; $display("FAIL t5_beat%0d_ack got=%b exp=1", b, ACK_O); end
      end
      tick;
      checks++; if (ACK_O !== 1'b0) begin errors++; $display("FAIL t5_eob_drop got=%b exp=0", ACK_O); end
      CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; CTI_I = 3'b000;
      tick;
      for (int b = 0; b < 8; b++) begin
         do_classic(1'b0, 32'h100 + 32'(b * 4), 32'h0, 4'hF, rd, n, e, aa, ea);
         checks++;
         if (rd !== 32'hA5000000 + 32'(b)) begin
            errors++; $display("FAIL t5_word%0d got=%h exp=%h", b, rd, 32'hA5000000 + 32'(b));
         end
      end
   endtask

   task automatic test_back_to_back_raw;
      CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; ADR_I = 32'h180; SEL_I = 4'hF;
      CTI_I = 3'b001; BTE_I = 2'b00; DAT_I = 32'hAAAA5555;
      tick;
      tick;
      tick;
      WE_I = 1'b0; CTI_I = 3'b111;
      checks++;
      if (ACK_O !== 1'b1 || DAT_O !== 32'hAAAA5555) begin
         errors++; $display("FAIL raw_const got ack=%b dat=%h exp ack=1 dat=aaaa5555", ACK_O, DAT_O);
      end
      tick;
      checks++; if (ACK_O !== 1'b0) begin errors++; $display("FAIL raw_eob_drop got=%b exp=0", ACK_O); end
      CYC_I = 1'b0; STB_I = 1'b0; CTI_I = 3'b000;
      tick;
   endtask

   task automatic test_burst_end_of_mem;
      CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0; ADR_I = 32'hFF8; SEL_I = 4'hF;
      CTI_I = 3'b010; BTE_I = 2'b00;
      tick;
      tick;
      checks++; if (ACK_O !== 1'b1) begin errors++; $display("FAIL eom_beat1022 got=%b exp=1", ACK_O); end
      tick;
      checks++; if (ACK_O !== 1'b1) begin errors++; $display("FAIL eom_beat1023 got=%b exp=1", ACK_O); end
      tick;
      checks++;
      if (ERR_O !== 1'b1 || ACK_O !== 1'b0) begin
         errors++; $display("FAIL eom_err got err=%b ack=%b exp err=1 ack=0", ERR_O, ACK_O);
      end
      tick;
      checks++; if (ERR_O !== 1'b0) begin errors++; $display("FAIL eom_err_once got=%b exp=0", ERR_O); end
      CYC_I = 1'b0; STB_I = 1'b0; CTI_I = 3'b000;
      tick;
   endtask

   task automatic test_abort;
      logic [31:0] rd; int n; logic e, aa, ea;
      CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0; ADR_I = 32'h18; SEL_I = 4'hF;
      CTI_I = 3'b010; BTE_I = 2'b00;
      tick;
      tick;
      RST_I = 1'b1;
      tick;
      checks++;
      if (ACK_O !== 1'b0 || DAT_O !== 32'h0) begin
         errors++; $display("FAIL t6_rst_mid got ack=%b dat=%h exp ack=0 dat=0", ACK_O, DAT_O);
      end
      RST_I = 1'b0; CYC_I = 1'b0; STB_I = 1'b0; CTI_I = 3'b000;
      tick;
      do_classic(1'b0, 32'h100, 32'h0, 4'hF, rd, n, e, aa, ea);
      checks++;
      if (n !== 2 || rd !== 32'hA5000000) begin
         errors++; $display("FAIL t6_after_rst got n=%0d dat=%h exp n=2 dat=a5000000", n, rd);
      end
      do_classic(1'b1, 32'h140, 32'h12345678, 4'hF, rd, n, e, aa, ea);
      CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; ADR_I = 32'h140; SEL_I = 4'hF;
      CTI_I = 3'b010; DAT_I = 32'hFEEDFACE;
      tick;
      tick;
      CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
      tick;
      checks++; if (ACK_O !== 1'b0) begin errors++; $display("FAIL t6_cyc_drop_ack got=%b exp=0", ACK_O); end
      CTI_I = 3'b000;
      do_classic(1'b0, 32'h140, 32'h0, 4'hF, rd, n, e, aa, ea);
      checks++;
      if (n !== 2 || rd !== 32'h12345678) begin
         errors++; $display("FAIL t6_no_commit got n=%0d dat=%h exp n=2 dat=12345678", n, rd);
      end
   endtask

   initial begin
      RST_I = 1'b1; ADR_I = '0; TGA_I = '0; DAT_I = '0; TGD_I = '0; WE_I = 1'b0;
      SEL_I = '0; STB_I = 1'b0; CYC_I = 1'b0; LOCK_I = 1'b0; CTI_I = '0; BTE_I = '0;
      TGC_I = '0;
      test_reset;
      test_classic;
      test_byte_sel;
      test_wrap_burst;
      test_out_of_range;
      test_gap_burst;
      test_back_to_back_raw;
      test_burst_end_of_mem;
      test_abort;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
